// File: rtl/mod_n_pkg.sv
// mod_n_pkg
// Shared definitions for the streaming modulo-N checker:
//   - clog2()     : constant ceil(log2(v)) helper used to size the remainder
//   - *_MIN/*_MAX : legal parameter ranges, checked at elaboration by the top
//   - next_rem()  : one remainder step, (r * 2^in_w + chunk) mod divisor,
//                   built from per-bit shift/conditional-subtract (no divider)
package mod_n_pkg;

  localparam int DIVISOR_MIN = 2;
  localparam int DIVISOR_MAX = 255;
  localparam int IN_W_MIN    = 1;
  localparam int IN_W_MAX    = 8;

  function automatic int clog2(input int v);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) res = i + 1;
    end
    return res;
  endfunction

  // Consumes the chunk MSB first. Because the running value is always below
  // divisor (<= 255) before each shift, 2*acc+1 fits in 9 bits and a single
  // conditional subtract restores it to 0..divisor-1.
  function automatic logic [7:0] next_rem(input logic [7:0] r,
                                          input logic [7:0] chunk,
                                          input int         divisor,
                                          input int         in_w);
    logic [8:0] acc;
    acc = {1'b0, r};
    for (int i = 7; i >= 0; i--) begin
      if (i < in_w) begin
        acc = {acc[7:0], chunk[i]};
        if (acc >= 9'(divisor)) acc = acc - 9'(divisor);
      end
    end
    return acc[7:0];
  endfunction

endpackage

// File: rtl/mod_n_step.sv
// mod_n_step
// Combinational remainder step for the stream checker.
// Ports:
//   r_in   : current remainder (0..DIVISOR-1)
//   start  : when high the chunk begins a new number (base remainder 0)
//   chunk  : IN_W-bit slice of the number, MSB first
//   r_out  : (base * 2^IN_W + chunk) mod DIVISOR
module mod_n_step
  import mod_n_pkg::*;
#(
  parameter int DIVISOR = 5,
  parameter int IN_W    = 1,
  localparam int REM_W  = clog2(DIVISOR)
) (
  input  logic [REM_W-1:0] r_in,
  input  logic             start,
  input  logic [IN_W-1:0]  chunk,
  output logic [REM_W-1:0] r_out
);

  logic [7:0] base;
  logic [7:0] chunk_ext;

  always_comb begin
    base      = start ? 8'd0 : 8'(r_in);
    chunk_ext = 8'(chunk);
    r_out     = REM_W'(next_rem(base, chunk_ext, DIVISOR, IN_W));
  end

endmodule

// File: rtl/mod_n_stream_checker.sv
// mod_n_stream_checker
// Tests a number streamed in IN_W-bit chunks (MSB first) for divisibility by
// DIVISOR, keeping only a running remainder.
// Ports:
//   clk, resetn          : clock (rising edge), async active-low reset
//   din_valid/din_start  : beat qualifier / first chunk of a new number
//   din [IN_W]           : chunk data
//   dout_valid           : one-cycle pulse after each accepted beat
//   dout                 : number so far divisible by DIVISOR
//   rem [REM_W]          : number so far mod DIVISOR
//   bit_cnt [CNT_W]      : bits in the current number, saturating
module mod_n_stream_checker
  import mod_n_pkg::*;
#(
  parameter int DIVISOR = 5,
  parameter int IN_W    = 1,
  parameter int CNT_W   = 16,
  localparam int REM_W  = clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din_valid,
  input  logic             din_start,
  input  logic [IN_W-1:0]  din,
  output logic             dout_valid,
  output logic             dout,
  output logic [REM_W-1:0] rem,
  output logic [CNT_W-1:0] bit_cnt
);

  if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX) begin : g_bad_divisor
    $error("mod_n_stream_checker: DIVISOR out of range 2..255");
  end
  if (IN_W < IN_W_MIN || IN_W > IN_W_MAX) begin : g_bad_in_w
    $error("mod_n_stream_checker: IN_W out of range 1..8");
  end

  // Extra headroom so the count plus IN_W (<= 8) cannot wrap before clamping.
  localparam int SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [REM_W-1:0] r_q, r_d, r_next;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SUM_W-1:0] cnt_sum;

  mod_n_step #(
    .DIVISOR (DIVISOR),
    .IN_W    (IN_W)
  ) u_step (
    .r_in  (r_q),
    .start (din_start),
    .chunk (din),
    .r_out (r_next)
  );

  always_comb begin
    r_d          = r_q;
    dout_d       = dout_q;
    bit_cnt_d    = bit_cnt_q;
    dout_valid_d = 1'b0;
    cnt_sum      = (din_start ? '0 : SUM_W'(bit_cnt_q)) + SUM_W'(IN_W);
    if (din_valid) begin
      r_d          = r_next;
      dout_d       = (r_next == '0);
      dout_valid_d = 1'b1;
      bit_cnt_d    = (cnt_sum > CNT_MAX) ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q          <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
    end else begin
      r_q          <= r_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign rem        = r_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_mod_n_stream_checker.sv
module tb_mod_n_stream_checker;

  localparam int N = 6;
  // Instance set: D5/W1, D3/W4, D7/W1, D5/W2 with 3-bit counter,
  // power-of-two D8/W3, and the upper bound D255/W8.
  localparam int P_D [N] = '{5, 3, 7, 5, 8, 255};
  localparam int P_W [N] = '{1, 4, 1, 2, 3, 8};
  localparam int P_C [N] = '{16, 16, 16, 3, 16, 8};

  logic       clk;
  logic       resetn;
  logic       din_valid;
  logic       din_start;
  logic [7:0] din_raw;

  logic [15:0] rem_a  [N];
  logic [15:0] cnt_a  [N];
  logic        dout_a [N];
  logic        dv_a   [N];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int mr   [N] = '{default: 0};
  int mcnt [N] = '{default: 0};
  bit mdout[N] = '{default: 0};
  bit mdv  [N] = '{default: 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int D  = P_D[gi];
    localparam int W  = P_W[gi];
    localparam int C  = P_C[gi];
    localparam int RW = $clog2(D);
    logic [RW-1:0] rem;
    logic [C-1:0]  cnt;
    logic          dout;
    logic          dv;
    mod_n_stream_checker #(.DIVISOR(D), .IN_W(W), .CNT_W(C)) u_dut (
      .clk        (clk),
      .resetn     (resetn),
      .din_valid  (din_valid),
      .din_start  (din_start),
      .din        (din_raw[W-1:0]),
      .dout_valid (dv),
      .dout       (dout),
      .rem        (rem),
      .bit_cnt    (cnt)
    );
    assign rem_a[gi]  = 16'(rem);
    assign cnt_a[gi]  = 16'(cnt);
    assign dout_a[gi] = dout;
    assign dv_a[gi]   = dv;
  end

  // Reference: plain arithmetic on the number's value modulo D.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        mr[i] <= 0; mcnt[i] <= 0; mdout[i] <= 0; mdv[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int chunk, base, nr, nc, cmax;
        if (din_valid) begin
          chunk = int'(din_raw) % (1 << P_W[i]);
          base  = din_start ? 0 : mr[i];
          nr    = (base * (1 << P_W[i]) + chunk) % P_D[i];
          cmax  = (1 << P_C[i]) - 1;
          nc    = (din_start ? 0 : mcnt[i]) + P_W[i];
          if (nc > cmax) nc = cmax;
          mr[i] <= nr; mcnt[i] <= nc; mdout[i] <= (nr == 0); mdv[i] <= 1;
        end else begin
          mdv[i] <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single compare process: every instance, every cycle.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("dv[%0d]", i),   int'(dv_a[i]),   int'(mdv[i]));
      chk($sformatf("rem[%0d]", i),  int'(rem_a[i]),  mr[i]);
      chk($sformatf("dout[%0d]", i), int'(dout_a[i]), int'(mdout[i]));
      chk($sformatf("cnt[%0d]", i),  int'(cnt_a[i]),  mcnt[i]);
    end
  end

  task automatic beat(input bit s, input logic [7:0] d);
    @(negedge clk);
    din_valid = 1'b1;
    din_start = s;
    din_raw   = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    $display("beat start=%0d din=0x%02h -> u0 rem=%0d dout=%0d cnt=%0d", s, d,
             rem_a[0], dout_a[0], cnt_a[0]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din_start = 1'($urandom);
      din_raw   = 8'($urandom);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input int i, input int r, input int d, input int c);
    chk({name, " model rem"}, mr[i], r);
    chk({name, " dut rem"},   int'(rem_a[i]), r);
    chk({name, " dut dout"},  int'(dout_a[i]), d);
    chk({name, " dut cnt"},   int'(cnt_a[i]), c);
    chk({name, " dut dv"},    int'(dv_a[i]), 1);
  endtask

  initial begin
    longint acc;
    int     exp_cnt [5] = '{2, 4, 6, 7, 7};
    din_valid = 1'b0;
    din_start = 1'b0;
    din_raw   = 8'h00;
    resetn    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rem", int'(rem_a[0]), 0);
    chk("reset dv",  int'(dv_a[0]), 0);
    chk("reset cnt", int'(cnt_a[0]), 0);

    // Deassert and feed a beat on the very next rising edge.
    @(negedge clk);
    resetn    = 1'b1;
    din_valid = 1'b1; din_start = 1'b1; din_raw = 8'h01;
    @(posedge clk); #1; din_valid = 1'b0;
    pin("s1b1", 0, 1, 0, 1);
    beat(0, 8'h00); pin("s1b2", 0, 2, 0, 2);
    beat(0, 8'h01); pin("s1b3", 0, 0, 1, 3);

    // 7 mod 5, then a fresh start discards it
    beat(1, 8'h01); beat(0, 8'h01); beat(0, 8'h01);
    pin("s2 seven", 0, 2, 0, 3);
    beat(1, 8'h00); pin("s2 restart", 0, 0, 1, 1);

    // 255 mod 3 with a gap, then back to back
    beat(1, 8'h0F);
    idle(3);
    chk("gap dv", int'(dv_a[1]), 0);
    chk("gap hold rem", int'(rem_a[1]), 0);
    beat(0, 8'h0F); pin("s3 gap", 1, 0, 1, 8);
    beat(1, 8'h0F); beat(0, 8'h0F); pin("s3 b2b", 1, 0, 1, 8);

    // Saturating 3-bit counter
    beat(1, 8'h00); pin("sat0", 3, 0, 1, exp_cnt[0]);
    for (int k = 1; k < 5; k++) begin
      beat(0, 8'h00);
      pin($sformatf("sat%0d", k), 3, 0, 1, exp_cnt[k]);
    end

    // 20-bit stream against a full-width integer mod 7
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 1));
      beat(k == 0, b);
      acc = (k == 0) ? longint'(b) : acc * 2 + longint'(b);
      chk($sformatf("wide7 bit%0d", k), int'(rem_a[2]), int'(acc % 7));
    end

    // Reset mid-number, then continue without start
    beat(1, 8'h01); beat(0, 8'h00);
    @(negedge clk); #2; resetn = 1'b0; #1;
    chk("async rst rem",  int'(rem_a[0]), 0);
    chk("async rst cnt",  int'(cnt_a[0]), 0);
    chk("async rst dout", int'(dout_a[0]), 0);
    @(negedge clk); resetn = 1'b1;
    beat(0, 8'h01); pin("post rst", 0, 1, 0, 1);

    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk); #2; resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
      end
      if ($urandom_range(0, 3) != 0) beat($urandom_range(0, 9) == 0, 8'($urandom));
      else idle($urandom_range(1, 2));
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_n_stream_checker.md
MOD_N_STREAM_CHECKER -- requirements
Module: mod_n_stream_checker

Interface
REQ-001 Parameter: DIVISOR, 5, modulus tested; legal range 2..255; out-of-range values SHALL cause an elaboration error.
REQ-002 Parameter: IN_W, 1, bits consumed per accepted beat, MSB-first; legal range 1..8.
REQ-003 Parameter: CNT_W, 16, width of the bit counter.
REQ-004 Derived constant: REM_W = clog2(DIVISOR).
REQ-005 Port: clk  input  1  clock; all state updates on rising edge.
REQ-006 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-007 Port: din_valid  input  1  beat qualifier; a beat is accepted when high at a rising edge.
REQ-008 Port: din_start  input  1  marks the accepted beat as the first chunk of a new number.
REQ-009 Port: din  input  IN_W  next chunk of the number, MSB of chunk = most significant.
REQ-010 Port: dout_valid  output  1  pulses high one cycle after each accepted beat.
REQ-011 Port: dout  output  1  high when the number received so far is divisible by DIVISOR.
REQ-012 Port: rem  output  REM_W  running remainder of the number received so far modulo DIVISOR.
REQ-013 Port: bit_cnt  output  CNT_W  bits received in the current number, saturating.

Function
REQ-014 Internal state SHALL be a remainder register r in 0..DIVISOR-1; no full-width accumulator SHALL exist.
REQ-015 On an accepted beat: r_next = (base * 2^IN_W + din) mod DIVISOR, where base = 0 if din_start else r.
REQ-016 The modulo SHALL be computed in one cycle, combinationally, with no divider.
REQ-017 Latency: dout, rem and bit_cnt SHALL reflect an accepted beat at the next rising edge, with dout_valid high for exactly that cycle.
REQ-018 rem SHALL equal r; dout SHALL equal (r_next == 0); both are registered.
REQ-019 bit_cnt SHALL load IN_W on an accepted start beat, add IN_W on other accepted beats, and saturate at 2^CNT_W-1.
REQ-020 When din_valid is low: r, rem, dout and bit_cnt SHALL hold; dout_valid SHALL be 0.
REQ-021 When din_valid is low, din_start and din SHALL be ignored.
REQ-022 Back-to-back valid beats SHALL be accepted every cycle with no bubbles.
REQ-023 Start beat while a number is in progress: the previous number SHALL be discarded without error.
REQ-024 Beats arriving before any start beat after reset SHALL extend from r = 0.
REQ-025 Power-of-two DIVISOR SHALL still use the general path and give correct results.
REQ-026 A saturated bit_cnt SHALL NOT affect r, dout or rem.

Reset
REQ-027 While resetn is low, the block SHALL hold r = 0, rem = 0, dout = 0, dout_valid = 0 and bit_cnt = 0, asynchronously.
REQ-028 Reset mid-number SHALL discard all progress; the first post-reset beat SHALL compute from r = 0.
REQ-029 The first accepted beat SHALL be the rising edge after resetn deasserts; no extra settle cycle is allowed.

Structure
REQ-030 Package mod_n_pkg SHALL hold the clog2 helper, the legal-range bounds and the pure function next_rem(r, chunk, DIVISOR, IN_W).
REQ-031 One sub-module, mod_n_step, SHALL implement the combinational remainder step (REQ-015); mod_n_stream_checker SHALL own all registers and control.
REQ-032 No debug $display SHALL be present in synthesizable code.

Verification
REQ-033 DIVISOR=5, IN_W=1: start+1, 0, 1 -> rem 1,2,0; dout 0,0,1; bit_cnt 1,2,3.
REQ-034 DIVISOR=5, IN_W=1: start+1, 1, 1 (7) -> final rem 2, dout 0; then start+0 -> rem 0, dout 1, bit_cnt 1.
REQ-035 DIVISOR=3, IN_W=4: start+0xF, 0xF (255) -> rem 0, dout 1, bit_cnt 8; insert 3 idle cycles between the beats -> dout_valid low during the gap and results identical.
REQ-036 DIVISOR=7, IN_W=1: 20-bit random stream -> each cycle rem matches a full-width integer model mod 7.
REQ-037 Reset asserted after the 2nd beat of 1,0,1 -> all outputs 0; then a beat of 1 without start -> rem 1, dout 0.
REQ-038 CNT_W=3, IN_W=2: 5 beats of 0b00 -> bit_cnt 2,4,6,7,7; dout stays 1.
